// File: rtl/slot_min_scanner_pkg.sv
// Shared sizing constants and FSM state type for the slot argmin scanner.
package slot_min_scanner_pkg;

  localparam int unsigned NUM_SLOTS = 7;
  localparam int unsigned VAL_W     = 9;
  localparam int unsigned IDX_W     = 3;
  localparam logic [VAL_W-1:0] SLOT_RESET = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/slot_min_scanner.sv
// Seven registered value slots with a sequential argmin scan over the first N
// slots, one comparison per cycle; the result is held until handshaked.
module slot_min_scanner
  import slot_min_scanner_pkg::*;
(
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              wr_valid_in,
  output logic                              wr_ready_out,
  input  logic [IDX_W-1:0]                  wr_index_in,
  input  logic [VAL_W-1:0]                  wr_value_in,
  input  logic [IDX_W-1:0]                  count_in,
  input  logic                              scan_start_in,
  output logic                              busy_out,
  output logic                              result_valid_out,
  input  logic                              result_ready_in,
  output logic [IDX_W-1:0]                  result_index_out,
  output logic [VAL_W-1:0]                  result_value_out,
  output logic [NUM_SLOTS-1:0][VAL_W-1:0]   vals_out
);

  state_t                          r_state;
  state_t                          w_next;
  logic [NUM_SLOTS-1:0][VAL_W-1:0] r_vals;
  logic [IDX_W-1:0]                r_n;
  logic [IDX_W-1:0]                r_k;
  logic [VAL_W-1:0]                w_cand;
  logic                            w_less;
  logic                            w_start;
  logic                            w_write;

  assign vals_out = r_vals;
  assign w_write  = wr_valid_in && wr_ready_out && (wr_index_in < IDX_W'(NUM_SLOTS));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // r_k == r_n marks that every active slot has been compared.
  always_comb begin
    w_next           = r_state;
    wr_ready_out     = 1'b0;
    busy_out         = 1'b0;
    result_valid_out = 1'b0;
    w_start          = 1'b0;
    case (r_state)
      IDLE: begin
        wr_ready_out = !scan_start_in;
        if (scan_start_in) begin
          w_start = 1'b1;
          w_next  = SCAN;
        end
      end
      SCAN: begin
        busy_out = 1'b1;
        if (r_k == r_n) begin
          w_next = HOLD;
        end
      end
      HOLD: begin
        busy_out         = 1'b1;
        wr_ready_out     = 1'b1;
        result_valid_out = 1'b1;
        if (result_ready_in) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_cand = SLOT_RESET;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (r_k == IDX_W'(i)) begin
        w_cand = r_vals[i];
      end
    end
  end

  assign w_less = w_cand < result_value_out;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_vals           <= {NUM_SLOTS{SLOT_RESET}};
      r_n              <= '0;
      r_k              <= '0;
      result_index_out <= '0;
      result_value_out <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (w_write && (wr_index_in == IDX_W'(i))) begin
          r_vals[i] <= wr_value_in;
        end
      end
      if (w_start) begin
        r_n              <= (count_in == '0) ? IDX_W'(1) : count_in;
        r_k              <= IDX_W'(1);
        result_index_out <= '0;
        result_value_out <= r_vals[0];
      end else if ((r_state == SCAN) && (r_k != r_n)) begin
        if (w_less) begin
          result_index_out <= r_k;
          result_value_out <= w_cand;
        end
        r_k <= r_k + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_slot_min_scanner.sv
// Self-checking bench for slot_min_scanner: vector table of scans plus
// hand-written sequences for write blocking, reset abort and back-to-back starts.
module tb_slot_min_scanner;
  import slot_min_scanner_pkg::*;

  logic                            clk;
  logic                            rst;
  logic                            wr_valid;
  logic                            wr_ready;
  logic [IDX_W-1:0]                wr_index;
  logic [VAL_W-1:0]                wr_value;
  logic [IDX_W-1:0]                count;
  logic                            scan_start;
  logic                            busy;
  logic                            res_valid;
  logic                            res_ready;
  logic [IDX_W-1:0]                res_index;
  logic [VAL_W-1:0]                res_value;
  logic [NUM_SLOTS-1:0][VAL_W-1:0] vals;

  slot_min_scanner dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .wr_valid_in      (wr_valid),
    .wr_ready_out     (wr_ready),
    .wr_index_in      (wr_index),
    .wr_value_in      (wr_value),
    .count_in         (count),
    .scan_start_in    (scan_start),
    .busy_out         (busy),
    .result_valid_out (res_valid),
    .result_ready_in  (res_ready),
    .result_index_out (res_index),
    .result_value_out (res_value),
    .vals_out         (vals)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] idx;
    logic [8:0] val;
  } exp_t;

  typedef struct {
    logic [2:0] count;
    logic [2:0] idx;
    logic [8:0] val;
    int         lat;
    int         hold;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_slot(input int idx, input int val);
    wr_valid = 1'b1;
    wr_index = 3'(idx);
    wr_value = 9'(val);
    check("wr_ready_idle", int'(wr_ready), 1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pop_and_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_index"}, int'(res_index), int'(e.idx));
      check({tag, "_value"}, int'(res_value), int'(e.val));
    end
  endtask

  task automatic run_scan(input vec_t v);
    int   c;
    exp_t e;
    e.idx = v.idx;
    e.val = v.val;
    count      = v.count;
    scan_start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    scan_start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    c = 0;
    while (!res_valid && c < 30) begin
      @(negedge clk);
      c++;
    end
    check("latency", c, v.lat);
    pop_and_compare("scan");
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check("hold_valid", int'(res_valid), 1);
      check("hold_index", int'(res_index), int'(e.idx));
      check("hold_value", int'(res_value), int'(e.val));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("valid_after_hs", int'(res_valid), 0);
    check("busy_after_hs", int'(busy), 0);
  endtask

  initial begin
    int c;
    int last;
    int nvalid;
    int saw_valid;
    exp_t e;
    logic [NUM_SLOTS-1:0][VAL_W-1:0] snap;

    vecs[0] = '{count: 3'd4, idx: 3'd1, val: 9'd12, lat: 4, hold: 0};
    vecs[1] = '{count: 3'd7, idx: 3'd5, val: 9'd5,  lat: 7, hold: 3};
    vecs[2] = '{count: 3'd1, idx: 3'd0, val: 9'd40, lat: 1, hold: 0};
    vecs[3] = '{count: 3'd2, idx: 3'd1, val: 9'd12, lat: 2, hold: 0};
    vecs[4] = '{count: 3'd6, idx: 3'd5, val: 9'd5,  lat: 6, hold: 1};
    vecs[5] = '{count: 3'd3, idx: 3'd1, val: 9'd12, lat: 3, hold: 0};

    rst = 1'b1; wr_valid = 1'b0; wr_index = '0; wr_value = '0;
    count = '0; scan_start = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_wr_ready", int'(wr_ready), 1);
    check("rst_valid", int'(res_valid), 0);
    check("rst_index", int'(res_index), 0);
    check("rst_value", int'(res_value), 0);
    for (int i = 0; i < NUM_SLOTS; i++) check("rst_slot", int'(vals[i]), 'h1FF);

    write_slot(0, 40); write_slot(1, 12); write_slot(2, 33); write_slot(3, 12);
    write_slot(4, 90); write_slot(5, 5);  write_slot(6, 70);
    snap = vals;
    write_slot(7, 3);
    for (int i = 0; i < NUM_SLOTS; i++) check("idx7_dropped", int'(vals[i]), int'(snap[i]));

    for (int i = 0; i < 6; i++) run_scan(vecs[i]);

    write_slot(0, 100);
    run_scan('{count: 3'd0, idx: 3'd0, val: 9'd100, lat: 1, hold: 0});

    // Write held through a scan: blocked until HOLD, then must not touch the result.
    count = 3'd7; scan_start = 1'b1;
    wr_valid = 1'b1; wr_index = 3'd5; wr_value = 9'd0;
    e.idx = 3'd5; e.val = 9'd5;
    sb.push_back(e);
    @(negedge clk);
    scan_start = 1'b0;
    c = 0;
    while (!res_valid && c < 30) begin
      check("scan_wr_ready", int'(wr_ready), 0);
      check("scan_slot5", int'(vals[5]), 5);
      @(negedge clk);
      c++;
    end
    check("wrhold_latency", c, 7);
    check("hold_wr_ready", int'(wr_ready), 1);
    check("hold_slot5_pre", int'(vals[5]), 5);
    pop_and_compare("wrhold");
    @(negedge clk);
    wr_valid = 1'b0;
    check("hold_slot5_post", int'(vals[5]), 0);
    check("wrhold_index_kept", int'(res_index), 5);
    check("wrhold_value_kept", int'(res_value), 5);
    check("wrhold_valid_kept", int'(res_valid), 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("wrhold_idle", int'(busy), 0);

    // Reset in the third SCAN cycle aborts the scan without a result.
    count = 3'd7; scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_scan", int'(busy), 1);
    rst = 1'b1; wr_valid = 1'b1; wr_index = 3'd2; wr_value = 9'd1;
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(res_valid), 0);
    for (int i = 0; i < NUM_SLOTS; i++) check("abort_slot", int'(vals[i]), 'h1FF);
    saw_valid = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid) saw_valid = 1;
      @(negedge clk);
    end
    check("abort_no_result", saw_valid, 0);

    // Start held high with ready high: a new scan every IDLE cycle, period 4 for N=2.
    write_slot(1, 7);
    e.idx = 3'd1; e.val = 9'd7;
    count = 3'd2; scan_start = 1'b1; res_ready = 1'b1;
    last = -1; nvalid = 0;
    for (int i = 0; i < 24; i++) begin
      if (!busy) sb.push_back(e);
      if (res_valid) begin
        pop_and_compare("b2b");
        if (last >= 0) check("b2b_gap", i - last, 4);
        last = i;
        nvalid++;
      end
      @(negedge clk);
    end
    scan_start = 1'b0; res_ready = 1'b0;
    check("b2b_count", nvalid, 6);
    check("b2b_sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/slot_min_scanner.md
SLOT_MIN_SCANNER -- requirements
Module: slot_min_scanner

Interface
REQ-001 The block SHALL have `clk_in`, input, width 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have `rst_in`, input, width 1, reset; synchronous and active-high.
REQ-003 The block SHALL have `wr_valid_in`, input, width 1, which requests a slot write.
REQ-004 The block SHALL have `wr_ready_out`, output, width 1, high when a write can be accepted.
REQ-005 The block SHALL have `wr_index_in`, input, width 3, the target slot 0..6.
REQ-006 The block SHALL have `wr_value_in`, input, width 9, the value to store.
REQ-007 The block SHALL have `count_in`, input, width 3, the number of active slots, sampled at scan start.
REQ-008 The block SHALL have `scan_start_in`, input, width 1, which requests an argmin scan.
REQ-009 The block SHALL have `busy_out`, output, width 1, high whenever the state is not IDLE.
REQ-010 The block SHALL have `result_valid_out`, output, width 1, which marks the scan result as valid.
REQ-011 The block SHALL have `result_ready_in`, input, width 1, the consumer's acceptance of the result.
REQ-012 The block SHALL have `result_index_out`, output, width 3, the index of the minimum slot.
REQ-013 The block SHALL have `result_value_out`, output, width 9, the value of the minimum slot.
REQ-014 The block SHALL have `vals_out`, output, packed [6:0][8:0], the registered slot contents for downstream combinational consumers.

Function
REQ-015 The block SHALL hold 7 registered 9-bit slots; a write occurs on an edge where wr_valid_in && wr_ready_out, and wr_index_in=7 SHALL be dropped silently.
REQ-016 wr_ready_out SHALL be high in IDLE or HOLD, except that it SHALL be low in IDLE while scan_start_in is high, so a scan never sees a mid-scan write.
REQ-017 The FSM SHALL have states IDLE, SCAN and HOLD, with these transitions: IDLE->SCAN on scan_start_in; SCAN->HOLD when the last active slot is compared; HOLD->IDLE on result_valid_out && result_ready_in.
REQ-018 At scan start, the effective count N SHALL be count_in, except that count_in=0 SHALL be treated as N=1; the block SHALL latch N, set best_index=0 and best_value=slot0.
REQ-019 In SCAN, the block SHALL compare slot k (k=1..N-1), one slot per cycle, and replace best only when slot_k < best_value (strict unsigned less-than), so ties keep the lowest index.
REQ-020 Latency: a start accepted at edge t SHALL give result_valid_out high from edge t+N, i.e. 1 cycle for N=1 and 7 cycles for N=7.
REQ-021 result_valid_out SHALL equal (state==HOLD); result_index_out and result_value_out SHALL be stable while valid and SHALL be held until the handshake completes.
REQ-022 Slot writes accepted in HOLD SHALL NOT alter the held result.
REQ-023 scan_start_in SHALL be ignored in SCAN and HOLD, and SHALL NOT be queued.
REQ-024 On back-to-back operation, a start asserted in the IDLE cycle directly after the HOLD handshake SHALL be accepted normally.
REQ-025 Slots with index >= N SHALL never be selected.

Reset
REQ-026 While rst_in is high at an edge, the block SHALL set all slots to 9'h1FF, state to IDLE, and result_index_out, result_value_out and result_valid_out to 0.
REQ-027 While rst_in is high at an edge, busy_out SHALL be 0 and wr_ready_out SHALL be 1 after the edge.
REQ-028 A reset asserted during SCAN or HOLD SHALL abort the operation with no result emitted; any write presented in the reset cycle SHALL be discarded.

Structure
REQ-029 A shared package SHALL hold NUM_SLOTS=7, VAL_W=9, IDX_W=3, SLOT_RESET=9'h1FF and the state enum typedef (IDLE, SCAN, HOLD).
REQ-030 The block SHALL be a single module with no sub-module; its comparator SHALL be one VAL_W-bit less-than reused each SCAN cycle.

Verification
REQ-031 The bench SHALL cover: write slots 0..6 = {40,12,33,12,90,5,70}, count_in=4, start -> after 4 cycles valid, index 1, value 12 (the tie with slot 3 resolves to the lower index).
REQ-032 The bench SHALL cover: same slots, count_in=7 -> index 5, value 5, valid exactly 7 cycles after start; with result_ready_in low for 3 cycles, the outputs stay constant.
REQ-033 The bench SHALL cover: count_in=0 with slot0=100 -> index 0, value 100, valid 1 cycle after start.
REQ-034 The bench SHALL cover: wr_valid_in held high through SCAN -> wr_ready_out is low and the slot is unchanged until HOLD; a write of slot5=0 in HOLD leaves the result unchanged, then vals_out[5]=0.
REQ-035 The bench SHALL cover: rst_in pulsed at the 3rd SCAN cycle -> no result_valid_out, busy_out=0, and every vals_out slot = 9'h1FF.
REQ-036 The bench SHALL cover: scan_start_in held continuously with result_ready_in=1 -> a new scan begins in each IDLE cycle, and no start is accepted in SCAN or HOLD.
